fetch_unit: RTL

Instruction fetch front end that owns the program counter and drives the instruction-memory request/response handshake. It produces `pc_plus_4F`, `instrF` and `validF`, the fetch-side inputs that the IF/ID pipeline register captures. It accepts redirects (taken branch/jump) and stalls from later stages, and allows one outstanding memory request at a time.

---
 rtl/fetch_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch front end. Owns the PC, runs a single
//            outstanding request/response handshake to instruction memory
//            and presents instrF / pc_plus_4F / validF to the IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_plus_4F,
  output logic [31:0] instrF,
  output logic        validF
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;

  // Redirect targets are always word aligned.
  logic [31:0] tgt_pc;
  assign tgt_pc = {redirect_pc[31:2], 2'b00};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // PC and presented-instruction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pcp4_q  <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
    end
  end

  // Next-state and datapath updates; redirect always wins over stall/data.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (redirect) begin
          // An accepted request at the old address must be drained in DROP.
          pc_d    = tgt_pc;
          state_d = imem_ready ? S_DROP : S_REQ;
        end else if (imem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid && redirect) begin
          pc_d    = tgt_pc;
          state_d = S_REQ;
        end else if (imem_rvalid) begin
          instr_d = imem_rdata;
          pcp4_d  = pc_q + 32'd4;
          state_d = S_HOLD;
        end else if (redirect) begin
          pc_d    = tgt_pc;
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = tgt_pc;
          state_d = S_REQ;
        end else if (!stallF) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect) begin
          pc_d = tgt_pc;
        end
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and PC.
  always_comb begin
    imem_req   = (state_q == S_REQ);
    imem_addr  = pc_q;
    validF     = (state_q == S_HOLD);
    instrF     = instr_q;
    pc_plus_4F = pcp4_q;
  end

endmodule
`default_nettype wire
